// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM-like memory port between the fetch and data masters
//
// Purpose:
//   Arbitrates inst/data requests onto a single mem_* request port. Once a
//   request is presented without acceptance, the grant is locked until the
//   slave takes the address. Every accepted request is recorded in an in-order
//   ownership FIFO so that each mem_data_ok/mem_rdata goes back to the master
//   that issued it. A fetch flush (inst_cancel) marks outstanding fetch
//   entries so their responses are dropped.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   inst_* / data_*  (in)       master request: req, wr, size, wstrb, addr, wdata
//   inst_cancel      (in)       discard all outstanding fetch responses
//   inst_addr_ok / data_addr_ok request accepted this cycle
//   inst_data_ok / data_data_ok response valid (combinational from mem_data_ok)
//   inst_rdata / data_rdata     response data (mem_rdata passed through)
//   mem_*            (out)      request to slave: req, wr, size, wstrb, addr, wdata
//   mem_addr_ok, mem_data_ok,
//   mem_rdata        (in)       slave accept, in-order response, response data
//   err_unexp        (out)      sticky: response arrived with nothing outstanding

module mem_bus_arbiter #(
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_unexp
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    // Owner encoding stored in the ordering FIFO
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Grant lock
    logic          lock_q, lock_d;
    logic          lock_own_q, lock_own_d;

    // Fetch starvation counter
    logic [SW-1:0] starve_q, starve_d;

    // Ordering FIFO: one owner bit and one discard bit per slot
    logic [MAX_OUT-1:0] own_q, own_d;
    logic [MAX_OUT-1:0] disc_q, disc_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic          err_q, err_d;

    // Combinational helpers
    logic          fifo_full;
    logic          fifo_empty;
    logic          starved;
    logic          grant_own;
    logic          grant_req;
    logic          push;
    logic          pop;
    logic          head_own;
    logic          head_disc;

    assign fifo_full  = (cnt_q == CW'(MAX_OUT));
    assign fifo_empty = (cnt_q == '0);
    assign starved    = (starve_q == SW'(STARVE_LIMIT));

    // Grant selection: held while locked, otherwise data first unless fetch
    // has waited through STARVE_LIMIT data grants or data is idle.
    always_comb begin
        grant_own = OWN_DATA;
        if (lock_q) begin
            grant_own = lock_own_q;
        end else if (data_req && !(starved && inst_req)) begin
            grant_own = OWN_DATA;
        end else if (inst_req) begin
            grant_own = OWN_INST;
        end
    end

    assign grant_req = (grant_own == OWN_DATA) ? data_req : inst_req;

    // No bypass when full: a pop in the same cycle does not open a slot early.
    assign mem_req   = grant_req & ~fifo_full & ~reset;
    assign mem_wr    = (grant_own == OWN_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (grant_own == OWN_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (grant_own == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (grant_own == OWN_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (grant_own == OWN_DATA) ? data_wdata : inst_wdata;

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & ~fifo_empty & ~reset;

    assign inst_addr_ok = push & (grant_own == OWN_INST);
    assign data_addr_ok = push & (grant_own == OWN_DATA);

    assign head_own  = own_q[rd_ptr_q];
    assign head_disc = disc_q[rd_ptr_q];

    // A cancel in the same cycle as the pop also suppresses that response.
    assign inst_data_ok = pop & (head_own == OWN_INST) & ~head_disc & ~inst_cancel;
    assign data_data_ok = pop & (head_own == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign err_unexp = err_q;

    // Next-state logic
    always_comb begin
        own_d      = own_q;
        disc_d     = disc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lock_d     = mem_req & ~mem_addr_ok;
        lock_own_d = grant_own;
        starve_d   = starve_q;
        err_d      = err_q | (mem_data_ok & fifo_empty);

        // Flush marks every fetch slot; stale slots get rewritten on push
        // anyway, so marking them too is harmless.
        if (inst_cancel) begin
            disc_d = disc_q | ~own_q;
        end

        if (push) begin
            own_d[wr_ptr_q]  = grant_own;
            disc_d[wr_ptr_q] = (grant_own == OWN_INST) & inst_cancel;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (data_addr_ok && inst_req) begin
            if (!starved) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (inst_addr_ok || !inst_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_own_q <= OWN_DATA;
            starve_q   <= '0;
            own_q      <= '0;
            disc_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            starve_q   <= starve_d;
            own_q      <= own_d;
            disc_q     <= disc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with a queue-based reference model

module tb_mem_bus_arbiter;

    localparam int MAX_OUT      = 4;
    localparam int STARVE_LIMIT = 3;
    localparam bit OI = 1'b0;
    localparam bit OD = 1'b1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        err_unexp;

    mem_bus_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_unexp(err_unexp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding transactions in issue order
    typedef struct packed {
        logic own;
        logic disc;
    } ent_t;

    ent_t mq[$];
    int   m_starve;
    bit   m_lock, m_lock_own, m_err;

    // Per-step stimulus controls
    bit          n_reset, n_aok, n_dok, n_cancel, i_gen, d_gen;
    logic [31:0] n_rdata, i_next_addr, d_next_addr;
    bit          i_busy, d_busy;

    // Observed outputs from the most recent step
    bit          c_iaok, c_daok, c_idok, c_ddok, c_mreq, c_err;
    logic [31:0] c_maddr;

    task automatic step();
        bit          g, ereq, acc, eidok, eddok, stray;
        ent_t        h;
        ent_t        ne;
        logic [31:0] pa, pw;
        logic [1:0]  ps;
        logic [3:0]  pst;
        logic        pwr;
        @(negedge clk);
        if (!i_busy && i_gen) begin
            i_busy     = 1'b1;
            inst_addr  = i_next_addr;
            inst_wr    = 1'($urandom);
            inst_size  = 2'($urandom);
            inst_wstrb = 4'($urandom);
            inst_wdata = $urandom;
        end
        if (!d_busy && d_gen) begin
            d_busy     = 1'b1;
            data_addr  = d_next_addr;
            data_wr    = 1'($urandom);
            data_size  = 2'($urandom);
            data_wstrb = 4'($urandom);
            data_wdata = $urandom;
        end
        inst_req    = i_busy;
        data_req    = d_busy;
        reset       = n_reset;
        mem_addr_ok = n_aok;
        mem_data_ok = n_dok;
        mem_rdata   = n_rdata;
        inst_cancel = n_cancel;
        #1;
        c_iaok  = inst_addr_ok;
        c_daok  = data_addr_ok;
        c_idok  = inst_data_ok;
        c_ddok  = data_data_ok;
        c_mreq  = mem_req;
        c_err   = err_unexp;
        c_maddr = mem_addr;

        if (n_reset) begin
            check("rst_mem_req", mem_req, 0);
            check("rst_inst_addr_ok", inst_addr_ok, 0);
            check("rst_data_addr_ok", data_addr_ok, 0);
            check("rst_inst_data_ok", inst_data_ok, 0);
            check("rst_data_data_ok", data_data_ok, 0);
            check("rst_err_unexp", err_unexp, 0);
            mq.delete();
            m_starve   = 0;
            m_lock     = 1'b0;
            m_lock_own = OD;
            m_err      = 1'b0;
            return;
        end

        if (m_lock)
            g = m_lock_own;
        else if (data_req && !(m_starve == STARVE_LIMIT && inst_req))
            g = OD;
        else if (inst_req)
            g = OI;
        else
            g = OD;

        ereq  = ((g == OD) ? data_req : inst_req) && (mq.size() < MAX_OUT);
        acc   = ereq && mem_addr_ok;
        eidok = 1'b0;
        eddok = 1'b0;
        stray = mem_data_ok && (mq.size() == 0);
        if (mem_data_ok && mq.size() > 0) begin
            h     = mq[0];
            eidok = (h.own == OI) && !h.disc && !inst_cancel;
            eddok = (h.own == OD);
        end

        check("mem_req", mem_req, ereq);
        if (ereq) begin
            pa  = (g == OD) ? data_addr  : inst_addr;
            pw  = (g == OD) ? data_wdata : inst_wdata;
            ps  = (g == OD) ? data_size  : inst_size;
            pst = (g == OD) ? data_wstrb : inst_wstrb;
            pwr = (g == OD) ? data_wr    : inst_wr;
            check("mem_addr", mem_addr, pa);
            check("mem_wdata", mem_wdata, pw);
            check("mem_ctl", {mem_wr, mem_size, mem_wstrb}, {pwr, ps, pst});
        end
        check("inst_addr_ok", inst_addr_ok, acc && (g == OI));
        check("data_addr_ok", data_addr_ok, acc && (g == OD));
        check("inst_data_ok", inst_data_ok, eidok);
        check("data_data_ok", data_data_ok, eddok);
        if (eidok) check("inst_rdata", inst_rdata, n_rdata);
        if (eddok) check("data_rdata", data_rdata, n_rdata);
        check("err_unexp", err_unexp, m_err);

        if (mem_data_ok && mq.size() > 0) void'(mq.pop_front());
        if (inst_cancel) begin
            foreach (mq[k]) if (mq[k].own == OI) mq[k].disc = 1'b1;
        end
        if (acc) begin
            ne.own  = g;
            ne.disc = (g == OI) && inst_cancel;
            mq.push_back(ne);
        end
        if (acc && g == OD && inst_req)
            m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
        else if ((acc && g == OI) || !inst_req)
            m_starve = 0;
        m_lock     = ereq && !mem_addr_ok;
        m_lock_own = g;
        if (stray) m_err = 1'b1;
        if (acc && g == OI) i_busy = 1'b0;
        if (acc && g == OD) d_busy = 1'b0;
    endtask

    task automatic drain();
        i_gen    = 1'b0;
        d_gen    = 1'b0;
        n_cancel = 1'b0;
        n_reset  = 1'b0;
        n_aok    = 1'b1;
        for (int k = 0; k < 60 && (i_busy || d_busy || mq.size() > 0); k++) begin
            n_dok   = (mq.size() > 0);
            n_rdata = $urandom;
            step();
        end
        check("drain_idle", {31'd0, (i_busy || d_busy || mq.size() != 0)}, 0);
        n_dok = 1'b0;
    endtask

    task automatic rstep();
        i_gen       = ($urandom % 3) != 0;
        d_gen       = ($urandom % 3) != 0;
        i_next_addr = $urandom;
        d_next_addr = $urandom;
        n_aok       = ($urandom % 4) != 0;
        n_dok       = (mq.size() > 0) && (($urandom % 2) != 0);
        n_rdata     = $urandom;
        n_cancel    = ($urandom % 10) == 0;
        n_reset     = ($urandom % 400) == 0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        inst_cancel = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        n_reset = 1; n_aok = 0; n_dok = 0; n_cancel = 0; i_gen = 0; d_gen = 0;
        n_rdata = 0; i_next_addr = 0; d_next_addr = 0; i_busy = 0; d_busy = 0;
        mq.delete(); m_starve = 0; m_lock = 0; m_lock_own = OD; m_err = 0;

        // Reset state with a request pending
        i_gen = 1; i_next_addr = 32'h1c00_0000;
        step();
        step();
        n_reset = 0;
        i_busy = 0; i_gen = 0;

        // Single fetch: accept in cycle 0, response in cycle 2
        i_gen = 1; i_next_addr = 32'h1c00_0000; n_aok = 1;
        step();
        check("t1_iaok_c0", c_iaok, 1);
        check("t1_maddr_c0", c_maddr, 32'h1c00_0000);
        i_gen = 0;
        step();
        n_dok = 1; n_rdata = 32'h0280_0000;
        step();
        check("t1_idok_c2", c_idok, 1);
        check("t1_ddok_c2", c_ddok, 0);
        n_dok = 0;

        // Data wins by default, then starvation forces fetch in the 4th cycle
        i_gen = 1; d_gen = 1; i_next_addr = 32'h1c00_0100; d_next_addr = 32'h0000_8000;
        for (int c = 0; c < 5; c++) begin
            n_dok = (mq.size() > 0);
            step();
            if (c == 0) begin
                check("t2_maddr", c_maddr, 32'h0000_8000);
                check("t2_daok", c_daok, 1);
            end
            check($sformatf("t3_iaok_c%0d", c), c_iaok, (c == 3));
            i_gen = 0;
        end
        drain();

        // Cancel: fetches A and B dropped, data C delivered
        i_gen = 1; n_aok = 1;
        step();
        step();
        i_gen = 0; d_gen = 1; n_cancel = 1;
        step();
        check("t4_c_daok", c_daok, 1);
        d_gen = 0; n_cancel = 0; n_dok = 1;
        for (int c = 0; c < 3; c++) begin
            n_rdata = $urandom;
            step();
            check($sformatf("t4_idok_%0d", c), c_idok, 0);
            check($sformatf("t4_ddok_%0d", c), c_ddok, (c == 2));
        end
        drain();

        // Lock: fetch held until accepted, then data
        i_gen = 1; i_next_addr = 32'h1c00_0040; n_aok = 0;
        for (int c = 0; c < 5; c++) begin
            n_aok = (c >= 3);
            step();
            if (c < 4) check($sformatf("t5_maddr_c%0d", c), c_maddr, 32'h1c00_0040);
            if (c == 3) check("t5_iaok", c_iaok, 1);
            if (c == 4) check("t5_daok", c_daok, 1);
            i_gen = 0; d_gen = 1;
        end
        drain();

        // Full FIFO blocks mem_req with no same-cycle bypass
        i_gen = 1; d_gen = 1; n_aok = 1;
        for (int c = 0; c < 8; c++) begin
            n_dok = (c == 6);
            step();
            check($sformatf("t6_mreq_c%0d", c), c_mreq, (c < 4 || c == 7));
        end
        drain();

        // Stray response sets a sticky error
        n_dok = 1;
        step();
        check("t7_stray_no_idok", c_idok, 0);
        check("t7_stray_no_ddok", c_ddok, 0);
        n_dok = 0;
        step();
        check("t7_err_set", c_err, 1);
        step();
        check("t7_err_sticky", c_err, 1);

        // Reset mid-traffic, then stray again
        for (int c = 0; c < 20; c++) begin
            rstep();
        end
        n_reset = 1; n_dok = 0;
        step();
        check("t8_rst_err", c_err, 0);
        step();
        n_reset = 0;
        drain();
        n_dok = 1;
        step();
        n_dok = 0;
        step();
        check("t8_err_after_rst", c_err, 1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rstep();
        end
        n_reset = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master and the data (load/store) master.
- Sits between the IF/MEM stages and the AXI bridge.
- Arbitrates new requests and locks the grant until the slave accepts the address.
- Tracks outstanding transactions in order, routes each data_ok/rdata back to its owner, and drops fetch responses cancelled by a pipeline flush.

Parameters:
MAX_OUT, 4, maximum outstanding accepted-but-unanswered transactions (power of 2, >=2)
STARVE_LIMIT, 3, consecutive data grants allowed while fetch is waiting before fetch is forced to win

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request
inst_wr  in  1  fetch write (normally 0)
inst_size  in  2  bytes = 1<<size
inst_wstrb  in  4  byte enables
inst_addr  in  32  fetch address
inst_wdata  in  32  fetch write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch response data
inst_cancel  in  1  discard all outstanding fetch responses (exception/ertn/branch flush)
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request, same meaning as fetch
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data response data
mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  request to slave
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response (strictly in issue order)
mem_rdata  in  32  slave response data
err_unexp  out  1  sticky: mem_data_ok arrived with no outstanding entry

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset state: lock cleared, FIFO empty, starve counter 0, err_unexp 0.
- Outputs while reset is asserted: mem_req, all *_addr_ok and all *_data_ok = 0.
- Reset mid-transaction drops all outstanding state. Later stray mem_data_ok sets err_unexp.
- Handshake: a request transfers when req & addr_ok. A master holds req and payload stable until its addr_ok.
- Grant source, unlocked:
  - The grant is combinational from current requests.
  - data wins by default.
  - inst wins if only inst requests, or if starve_cnt == STARVE_LIMIT and inst_req.
- Grant source, locked: if mem_req was 1 last cycle without mem_addr_ok, the grant is held to the same owner. Lock clears on mem_addr_ok.
- Starve counter:
  - Increments on a data transfer while inst_req=1, saturating at STARVE_LIMIT.
  - Clears on an inst transfer or when inst_req=0.
- Request mux: mem_* = granted master's payload.
  - mem_req = granted req & ~fifo_full.
  - While full, mem_req=0 even if a pop occurs the same cycle (no bypass).
  - A lock cannot coexist with full, because lock requires mem_req=1.
- Address accept routing: inst_addr_ok = mem_req & mem_addr_ok & grant==inst; data_addr_ok likewise for data.
- Ordering FIFO: depth MAX_OUT; each entry is {owner, discard}.
  - Push on mem_req & mem_addr_ok.
  - Pop on mem_data_ok when non-empty.
  - Push and pop in the same cycle leave the count unchanged; pointers wrap modulo MAX_OUT.
- Response routing:
  - inst_data_ok = mem_data_ok & head.owner==inst & ~head.discard.
  - data_data_ok = mem_data_ok & head.owner==data.
  - inst_rdata = data_rdata = mem_rdata.
  - Response latency is 0 cycles (combinational).
- Cancel:
  - inst_cancel sets discard on every valid inst entry, including an inst entry pushed the same cycle.
  - The entry being popped that cycle is also suppressed.
  - Data entries are unaffected.
  - Cancel does not block new requests in the same cycle; a request from the flushed target path may be accepted.
- Empty-FIFO response: mem_data_ok with an empty FIFO is not forwarded to either master and sets err_unexp, which stays set until reset.

Test Plan:
- Only inst_req, addr 0x1c000000, mem_addr_ok same cycle, data_ok 2 cycles later with rdata 0x02800000 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with 0x02800000 in cycle 2; data_data_ok=0.
- inst_req and data_req both high, FIFO empty, starve_cnt 0 -> data granted (mem_addr = data_addr); inst waits; data_addr_ok only.
- data_req held high, inst_req high, mem_addr_ok every cycle, STARVE_LIMIT=3 -> grants D,D,D,I,D... ; inst_addr_ok in the 4th cycle.
- Issue inst A, then inst B, raise inst_cancel, issue data C, slave returns A,B,C -> no inst_data_ok for A or B; data_data_ok for C only.
- mem_addr_ok held 0 for 3 cycles with inst granted, data_req rising in cycle 1 -> mem_addr stays the inst address until accept; data granted afterward.
- 4 accepts with no data_ok -> mem_req=0 even with requests pending; one data_ok re-enables mem_req the next cycle.
- mem_data_ok with empty FIFO -> err_unexp=1 and sticky; assert reset mid-traffic -> outputs 0 and FIFO empty.
